// File: rtl/sram_port_pkg.sv
// sram_port_pkg: shared defaults and response-entry type for the SRAM port master.
package sram_port_pkg;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam int DEF_MEM_WORDS = 4096;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;
endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: 2-entry in-order response buffer with occupancy count.
module sram_rsp_fifo
  import sram_port_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       push,
  input  logic       pop,
  input  rsp_t       din,
  output rsp_t       head,
  output logic [1:0] count
);
  rsp_t mem [2];
  logic rd, wr;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd     <= 1'b0;
      wr     <= 1'b0;
      count  <= 2'd0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= !wr;
      end
      if (pop) rd <= !rd;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  assign head = mem[rd];
endmodule

// File: rtl/sram_port_master.sv
// sram_port_master: valid/ready command bus to single-port synchronous RAM macro,
// in-order read responses via bypass or 2-entry buffer.
module sram_port_master
  import sram_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          MEM_WORDS = DEF_MEM_WORDS,
  parameter int          ADDR_W    = 12
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [31:0]       cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [3:0]        cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [31:0]       ram_d,
  output logic [3:0]        ram_wem,
  output logic              ram_we,
  output logic              ram_me,
  output logic              ram_oe,
  input  logic [31:0]       ram_q
);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);
  logic [31:0] off;
  logic        inr, acc, pend, pend_err, push, pop, busy;
  logic [1:0]  count;
  rsp_t        head, bypass;
  assign off       = cmd_addr - BASE_ADDR;
  assign inr       = off < SPAN;
  // credits count both buffered and in-flight reads, so a pend cycle never overflows
  assign cmd_ready = RST_N & ((count + {1'b0, pend}) < 2'd2);
  assign acc       = cmd_valid & cmd_ready;
  assign ram_adr   = off[ADDR_W+1:2];
  assign ram_d     = cmd_data;
  assign ram_wem   = cmd_mask;
  assign ram_me    = acc & inr;
  assign ram_we    = acc & inr & cmd_wr;
  assign ram_oe    = RST_N;
  assign bypass    = {pend_err ? 32'h0 : ram_q, pend_err};
  assign busy      = count != 2'd0;
  assign push      = pend & !(!busy & rsp_ready);
  assign pop       = busy & rsp_ready;
  assign rsp_valid = busy | pend;
  assign rsp_data  = busy ? head.data : pend ? bypass.data : 32'h0;
  assign rsp_err   = busy ? head.err : pend & pend_err;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend     <= 1'b0;
      pend_err <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      pend     <= acc & !cmd_wr;
      pend_err <= !inr;
      wr_err   <= wr_err | (acc & cmd_wr & !inr);
    end
  end
  sram_rsp_fifo u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push),
    .pop   (pop),
    .din   (bypass),
    .head  (head),
    .count (count)
  );
endmodule
